spi_segment_mux_controller: RTL
===============================

SPI_SEGMENT_MUX_CONTROLLER -- requirements
Module: spi_segment_mux_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 Parameter REFRESH_DIV, default 16, clk cycles each digit is held active (range 2..2^16).
REQ-003 Parameter SEG_ACTIVE_LOW, default 0, when 1 seg_out and digit_en are inverted at the output.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 ena  input  1  display enable; low blanks the outputs.
REQ-007 spi_sck  input  1  SPI clock, asynchronous to clk, mode 0.
REQ-008 spi_cs_n  input  1  SPI chip select, active low.
REQ-009 spi_mosi  input  1  SPI data in, MSB first.
REQ-010 spi_miso  output  1  SPI data out, MSB first.
REQ-011 seg_out  output  8  segments {dp,g,f,e,d,c,b,a} of the active digit.
REQ-012 digit_en  output  NUM_DIGITS  one-hot digit select.
REQ-013 frame_done  output  1  one-cycle pulse per committed frame.

Function
REQ-014 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchroniser; SCK edges are detected on the synchronised signal (SCK period >= 8 clk cycles).
REQ-015 A frame SHALL be 16 bits sampled on synchronised SCK rising edges while CS is low: bit15 raw flag, bits14:8 digit address, bits7:0 data.
REQ-016 On the 16th rising edge the frame SHALL commit: raw=1 stores data to digit[addr]; raw=0 stores hex-decode(data[3:0]) with dp=data[7].
REQ-017 Addresses >= NUM_DIGITS SHALL be discarded without register change, while frame_done still pulses.
REQ-018 frame_done SHALL pulse high for exactly one clk cycle, on the cycle following commit.
REQ-019 CS rising before 16 bits SHALL abort the frame; no register change, no frame_done.
REQ-020 Bits beyond 16 in one CS-low window SHALL start a new frame (back-to-back frames allowed).
REQ-021 On CS falling, the MISO shift register SHALL load {8'hA5, NUM_DIGITS[7:0]}; bit15 drives spi_miso immediately, then it shifts on each synchronised SCK falling edge; spi_miso = 0 while CS high.
REQ-022 Hex decode (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-023 Scan counter SHALL count 0..REFRESH_DIV-1; on wrap the digit index advances modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
REQ-024 seg_out and digit_en SHALL be registered, one clk after the index and digit register values they reflect.
REQ-025 digit_en = one-hot(index) and seg_out = digit[index] when ena=1; both all-zero (before polarity) when ena=0; the scan keeps running.
REQ-026 A commit to the currently displayed digit SHALL appear on seg_out one cycle after the digit register updates.

Reset
REQ-027 While rst_n=0 at a clk edge: all digit registers 0, scan counter 0, index 0, seg_out/digit_en 0 (polarity applied), frame_done 0, spi_miso 0, bit counter 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; a new frame begins only at the next CS falling edge after reset release.

Structure
REQ-029 Package seg_ctrl_pkg SHALL hold FRAME_BITS=16, ID_BYTE=8'hA5, and the hex-to-segment table/function.
REQ-030 Sub-module spi_frame_rx SHALL contain the synchronisers, edge detection, bit counter, RX/TX shift registers and commit strobe; the top holds digit registers and scan logic.

Verification
REQ-031 Reset, ena=1, NUM_DIGITS=4, REFRESH_DIV=16 -> digit_en walks 0001,0010,0100,1000,0001 every 16 cycles; seg_out=00.
REQ-032 Frame 16'h0205 -> frame_done one pulse; when digit_en=0100, seg_out=6D.
REQ-033 Frame 16'h81C0 then 16'h008A -> digit1 seg_out=C0; digit0 seg_out=F7.
REQ-034 Frame 16'h0907 (addr 9) -> frame_done pulses, all digit registers unchanged.
REQ-035 CS raised after 10 bits of 16'h0003 -> no frame_done, digit0 unchanged; next full frame commits normally.
REQ-036 Any frame -> MISO captured on SCK rising = 16'hA504; ena=0 -> seg_out=00, digit_en=0000 (FF/1111 with SEG_ACTIVE_LOW=1).

Source files
------------

// File: rtl/seg_ctrl_pkg.sv
// Shared constants, receiver state type and the hex-to-segment decode
// used by the SPI-driven segment multiplexer.
package seg_ctrl_pkg;

    localparam int         FRAME_BITS = 16;
    localparam logic [7:0] ID_BYTE    = 8'hA5;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_ACTIVE = 1'b1
    } rx_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a lit segment is 1.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/spi_segment_mux_controller_if.sv
// SPI pins of the segment controller, grouped so the bus can be passed as one port.
// Protocol: mode 0, CS active low; MOSI sampled on SCK rise, MISO changes on SCK fall, MSB first.
interface spi_segment_mux_controller_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sck, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sck, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_frame_rx.sv
// SPI slave front end: synchronises the pins into clk, assembles 16-bit frames,
// pulses commit per complete frame and shifts out the ID word on MISO.
module spi_frame_rx
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_segment_mux_controller_if.slave   spi,
    output logic                          commit,
    output logic [FRAME_BITS-1:0]         frame,
    output rx_state_e                     state
);

    logic [1:0]            sck_sync_q, sck_sync_d;
    logic [1:0]            cs_sync_q, cs_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic                  sck_prev_q, sck_prev_d;
    logic                  cs_prev_q, cs_prev_d;
    rx_state_e             state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic                  commit_q, commit_d;

    logic sck_rise, sck_fall, cs_fall, cs_high;

    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
    assign cs_fall  = cs_prev_q & ~cs_sync_q[1];
    assign cs_high  = cs_sync_q[1];

    always_comb begin
        sck_sync_d  = {sck_sync_q[0], spi.spi_sck};
        cs_sync_d   = {cs_sync_q[0], spi.spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], spi.spi_mosi};
        sck_prev_d  = sck_sync_q[1];
        cs_prev_d   = cs_sync_q[1];
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        commit_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (cs_fall) begin
                    state_d   = RX_ACTIVE;
                    bit_cnt_d = '0;
                    tx_d      = {ID_BYTE, 8'(NUM_DIGITS)};
                end
            end
            default: begin
                // A CS rise always wins: any partial frame is dropped.
                if (cs_high) begin
                    state_d   = RX_IDLE;
                    bit_cnt_d = '0;
                end else if (sck_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync_q[1]};
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        commit_d  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (sck_fall) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        endcase
    end

    // CS sync resets low so a CS held low across reset is not seen as a new falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            commit_q    <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            commit_q    <= commit_d;
        end
    end

    assign commit       = commit_q;
    assign frame        = rx_q;
    assign state        = state_q;
    assign spi.spi_miso = (state_q == RX_ACTIVE) & tx_q[FRAME_BITS-1];

endmodule

// File: rtl/spi_segment_mux_controller.sv
// Multiplexed 7-segment driver: digit registers written by SPI frames,
// scanned one digit at a time with registered segment/digit outputs.
module spi_segment_mux_controller
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    spi_segment_mux_controller_if.slave   spi,
    output logic [7:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done,
    output rx_state_e                     dbg_rx_state
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic                  commit;
    logic [FRAME_BITS-1:0] frame;
    logic                  raw;
    logic [6:0]            addr;
    logic [7:0]            data;

    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] den_q, den_d;
    logic                  frame_done_q, frame_done_d;

    spi_frame_rx #(.NUM_DIGITS(NUM_DIGITS)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .spi    (spi),
        .commit (commit),
        .frame  (frame),
        .state  (dbg_rx_state)
    );

    assign raw  = frame[15];
    assign addr = frame[14:8];
    assign data = frame[7:0];

    always_comb begin
        digit_d      = digit_q;
        frame_done_d = commit;
        // Out-of-range addresses match no register and are silently dropped.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && (32'(addr) == i)) begin
                digit_d[i] = raw ? data : {data[7], hex_to_seg(data[3:0])};
            end
        end
        if (32'(scan_cnt_q) == REFRESH_DIV - 1) begin
            scan_cnt_d = '0;
            idx_d      = (32'(idx_q) == NUM_DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
        end else begin
            scan_cnt_d = scan_cnt_q + CNT_W'(1);
            idx_d      = idx_q;
        end
        seg_d = '0;
        den_d = '0;
        if (ena) begin
            seg_d = digit_q[idx_q];
            for (int i = 0; i < NUM_DIGITS; i++) begin
                den_d[i] = (32'(idx_q) == i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q      <= '{default: '0};
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            seg_q        <= '0;
            den_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            digit_q      <= digit_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            den_q        <= den_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign digit_en   = SEG_ACTIVE_LOW ? ~den_q : den_q;
    assign frame_done = frame_done_q;

endmodule
